// File: rtl/j_upcntn.sv
// j_upcntn: cascadable WIDTH-bit counter with clear, load, reload register and free-run/one-shot/auto-reload terminal modes.
// Defining J_UPCNTN_DOWN_EN adds the dn input for down counting (terminal value 0, co becomes borrow-out).
module j_upcntn #(
   parameter int WIDTH = 16
) (
   input  logic             sys_clk,
   input  logic             resl,
   input  logic             ci,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       mode,
`ifdef J_UPCNTN_DOWN_EN
   input  logic             dn,
`endif
   output logic [WIDTH-1:0] q,
   output logic             co,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] rld_r;
   logic             tc_r;
   logic             done_r;
   logic [WIDTH-1:0] q_nxt_s;
   logic [WIDTH-1:0] rld_nxt_s;
   logic             tc_nxt_s;
   logic             done_nxt_s;
   logic [WIDTH-1:0] term_s;
   logic [WIDTH-1:0] step_s;
   logic             dn_s;
   logic             at_term_s;

`ifdef J_UPCNTN_DOWN_EN
   assign dn_s = dn;
`else
   assign dn_s = 1'b0;
`endif

   // Terminal value and single step in the current direction; the step wraps modulo 2^WIDTH
   always_comb begin
      term_s = ONES;
      step_s = q_r + ONE;
      if (dn_s) begin
         term_s = ZERO;
         step_s = q_r - ONE;
      end else begin
         term_s = ONES;
         step_s = q_r + ONE;
      end
   end

   assign at_term_s = (q_r == term_s);
   // Carry/borrow is combinational so a whole stack of stages advances in the same cycle
   assign co        = ci & at_term_s & ~done_r;

   // Next state: clr beats ld beats count; an expired one-shot ignores ci
   always_comb begin
      q_nxt_s    = q_r;
      rld_nxt_s  = rld_r;
      tc_nxt_s   = 1'b0;
      done_nxt_s = done_r;
      if (clr) begin
         q_nxt_s    = ZERO;
         done_nxt_s = 1'b0;
      end else if (ld) begin
         q_nxt_s    = d;
         rld_nxt_s  = d;
         done_nxt_s = 1'b0;
      end else if (ci && !done_r) begin
         if (!at_term_s) begin
            q_nxt_s = step_s;
         end else begin
            tc_nxt_s = 1'b1;
            case (mode)
               2'b01: begin
                  q_nxt_s    = q_r;
                  done_nxt_s = 1'b1;
               end
               2'b10:   q_nxt_s = rld_r;
               default: q_nxt_s = step_s;
            endcase
         end
      end else begin
         q_nxt_s = q_r;
      end
   end

   // State registers
   always_ff @(posedge sys_clk or negedge resl) begin
      if (!resl) begin
         q_r    <= ZERO;
         rld_r  <= ZERO;
         tc_r   <= 1'b0;
         done_r <= 1'b0;
      end else begin
         q_r    <= q_nxt_s;
         rld_r  <= rld_nxt_s;
         tc_r   <= tc_nxt_s;
         done_r <= done_nxt_s;
      end
   end

   assign q    = q_r;
   assign tc   = tc_r;
   assign done = done_r;

endmodule

// File: tb/tb_j_upcntn.sv
// Scoreboard bench for j_upcntn: a 4-bit DUT for directed tests plus a two-stage 4-bit cascade.
module tb_j_upcntn;

   logic       sys_clk;
   logic       resl;
   logic       ci;
   logic       clr;
   logic       ld;
   logic [3:0] d;
   logic [1:0] mode;
   logic [3:0] q;
   logic       co;
   logic       tc;
   logic       done;
`ifdef J_UPCNTN_DOWN_EN
   logic       dn_v;
   logic       dn_req;
`endif

   logic       c_ci;
   logic [3:0] q_lo;
   logic [3:0] q_hi;
   logic       co_lo;
   logic       co_hi;
   logic       tc_lo;
   logic       tc_hi;
   logic       done_lo;
   logic       done_hi;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic       kind;
      logic [3:0] q;
      logic       tc;
      logic       done;
      logic       co;
      logic [7:0] cq;
      logic [1:0] ctc;
      logic       cco;
   } exp_t;

   exp_t sb_q[$];

   j_upcntn #(.WIDTH(4)) u_dut (
      .sys_clk(sys_clk), .resl(resl), .ci(ci), .clr(clr), .ld(ld), .d(d), .mode(mode),
`ifdef J_UPCNTN_DOWN_EN
      .dn(dn_v),
`endif
      .q(q), .co(co), .tc(tc), .done(done)
   );

   j_upcntn #(.WIDTH(4)) u_lo (
      .sys_clk(sys_clk), .resl(resl), .ci(c_ci), .clr(1'b0), .ld(1'b0), .d(4'h0), .mode(2'b00),
`ifdef J_UPCNTN_DOWN_EN
      .dn(1'b0),
`endif
      .q(q_lo), .co(co_lo), .tc(tc_lo), .done(done_lo)
   );

   j_upcntn #(.WIDTH(4)) u_hi (
      .sys_clk(sys_clk), .resl(resl), .ci(co_lo), .clr(1'b0), .ld(1'b0), .d(4'h0), .mode(2'b00),
`ifdef J_UPCNTN_DOWN_EN
      .dn(1'b0),
`endif
      .q(q_hi), .co(co_hi), .tc(tc_hi), .done(done_hi)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One main-DUT cycle: drive at negedge, queue expected pre-edge co and post-edge state
   task automatic cyc(input logic c_clr, input logic c_ld, input logic [3:0] c_d, input logic c_cin,
                      input logic [1:0] c_mode, input logic [3:0] eq, input logic etc,
                      input logic edone, input logic eco);
      exp_t e;
      @(negedge sys_clk);
      clr  = c_clr;
      ld   = c_ld;
      d    = c_d;
      ci   = c_cin;
      mode = c_mode;
`ifdef J_UPCNTN_DOWN_EN
      dn_v = dn_req;
`endif
      e      = '0;
      e.kind = 1'b0;
      e.q    = eq;
      e.tc   = etc;
      e.done = edone;
      e.co   = eco;
      sb_q.push_back(e);
   endtask

   // One cascade cycle with the low stage enabled
   task automatic ccyc(input logic [7:0] ecq, input logic [1:0] ectc, input logic ecco);
      exp_t e;
      @(negedge sys_clk);
      c_ci   = 1'b1;
      e      = '0;
      e.kind = 1'b1;
      e.cq   = ecq;
      e.ctc  = ectc;
      e.cco  = ecco;
      sb_q.push_back(e);
   endtask

   // Monitor: co just after inputs settle, registered state just after the edge
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge sys_clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q[0];
            if (!e.kind) chk("co", {7'd0, co}, {7'd0, e.co});
            @(posedge sys_clk);
            #1;
            e = sb_q.pop_front();
            if (e.kind) begin
               chk("casc_q", {q_hi, q_lo}, e.cq);
               chk("casc_tc", {6'd0, tc_hi, tc_lo}, {6'd0, e.ctc});
               chk("casc_co", {7'd0, co_hi}, {7'd0, e.cco});
               chk("casc_done", {6'd0, done_hi, done_lo}, 8'd0);
            end else begin
               chk("q", {4'd0, q}, {4'd0, e.q});
               chk("tc", {7'd0, tc}, {7'd0, e.tc});
               chk("done", {7'd0, done}, {7'd0, e.done});
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [3:0] pre;
      resl = 1'b0;
      ci   = 1'b0;
      clr  = 1'b0;
      ld   = 1'b0;
      d    = 4'h0;
      mode = 2'b00;
      c_ci = 1'b0;
`ifdef J_UPCNTN_DOWN_EN
      dn_v   = 1'b0;
      dn_req = 1'b0;
`endif
      #2;
      chk("rst_q", {4'd0, q}, 8'd0);
      chk("rst_tc", {7'd0, tc}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      @(negedge sys_clk);
      resl = 1'b1;

      // Cascade: 257 edges of the two-stage 8-bit count
      for (int k = 1; k <= 257; k++)
         ccyc(8'(k), {(k == 256) ? 1'b1 : 1'b0, (k % 16 == 0) ? 1'b1 : 1'b0}, (k == 255) ? 1'b1 : 1'b0);
      @(negedge sys_clk);
      c_ci = 1'b0;

      // Free-run wrap from 0
      for (int k = 0; k <= 16; k++)
         cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b00, 4'(k + 1), (k == 15), 1'b0, (k == 15));

      // One-shot
      cyc(1'b0, 1'b1, 4'hD, 1'b0, 2'b01, 4'hD, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b01, 4'hE, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b01, 4'hF, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b01, 4'hF, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b01, 4'hF, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b00, 4'hF, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 4'h0, 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);

      // Auto-reload from C
      cyc(1'b0, 1'b1, 4'hC, 1'b0, 2'b10, 4'hC, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
         pre = 4'(12 + (k % 4));
         cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b10, (k % 4 == 3) ? 4'hC : 4'(pre + 4'h1),
             (k % 4 == 3), 1'b0, (k % 4 == 3));
      end

      // Priority: clr+ld leaves reload at C, seen when the count reaches F in mode 10
      cyc(1'b1, 1'b1, 4'h7, 1'b0, 2'b10, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 15; k++)
         cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b00, 4'(k + 1), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b10, 4'hC, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 4'h7, 1'b0, 2'b00, 4'h7, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'hF, 1'b0, 2'b00, 4'hF, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 4'h3, 1'b1, 2'b00, 4'h3, 1'b0, 1'b0, 1'b1);

      // Reload of all ones: q pinned at F with tc every cycle; then reserved mode wraps
      cyc(1'b0, 1'b1, 4'hF, 1'b0, 2'b10, 4'hF, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
         cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b10, 4'hF, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b11, 4'h0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'h0, 1'b0, 2'b11, 4'h0, 1'b0, 1'b0, 1'b0);

      // Async reset while q=9 and tc is high
      cyc(1'b0, 1'b1, 4'h9, 1'b0, 2'b10, 4'h9, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++)
         cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b10, 4'(10 + k), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b10, 4'h9, 1'b1, 1'b0, 1'b1);
      @(posedge sys_clk);
      #3;
      resl = 1'b0;
      #1;
      chk("arst_q", {4'd0, q}, 8'd0);
      chk("arst_tc", {7'd0, tc}, 8'd0);
      chk("arst_done", {7'd0, done}, 8'd0);
      ci = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      resl = 1'b1;

`ifdef J_UPCNTN_DOWN_EN
      // Down count through 0 in mode 00
      dn_req = 1'b1;
      cyc(1'b0, 1'b1, 4'h1, 1'b0, 2'b00, 4'h1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b00, 4'hF, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 4'h0, 1'b1, 2'b00, 4'hE, 1'b0, 1'b0, 1'b0);
      dn_req = 1'b0;
`endif

      repeat (3) @(posedge sys_clk);
      #2;
      chk("drain", 8'(sb_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/j_upcntn.md
Name: j_upcntn

Overview:
Parametrised N-bit cascadable up counter. It generalises the Jerry 1-bit counter slice (ci/co carry chain) into a full-width word counter with:
- synchronous clear and load
- a reload register
- three terminal-count modes: free-run wrap, one-shot, auto-reload
It feeds the Jerry timer/prescaler paths and stacks via ci/co for wider counts.

Parameters:
WIDTH, 16, counter and reload register width in bits (legal range 2..32)

Ports:
sys_clk  in   1      system clock; all state changes on its rising edge
resl     in   1      asynchronous active-low reset
ci       in   1      count enable / carry in from the lower stage
clr      in   1      synchronous clear
ld       in   1      synchronous load of d into q and into the reload register
d        in   WIDTH  load value
mode     in   2      00 free-run wrap, 01 one-shot, 10 auto-reload, 11 reserved (acts as 00)
q        out  WIDTH  current count (registered)
co       out  1      carry out to the next stage (combinational)
tc       out  1      terminal-count pulse (registered, one cycle)
done     out  1      one-shot expired flag (sticky)

Behaviour:
- Clocking and reset: one clock (sys_clk). Reset is asynchronous, active-low (resl). resl=0 forces q=0, rld=0, tc=0, done=0 immediately. Release is sampled on the next sys_clk edge.
- TERM = all ones (up count).
- Per-edge priority, highest first: clr > ld > count.
- clr=1: q<=0, done<=0, tc<=0. The reload register (rld) is unchanged.
- ld=1 (clr=0): q<=d, rld<=d, done<=0, tc<=0. Any coincident ci is ignored.
- Count step (clr=0, ld=0, ci=1, done=0):
  - q!=TERM: q<=q+1, tc<=0.
  - q==TERM, mode 00/11: q<=0, tc<=1.
  - q==TERM, mode 01: q stays at TERM, done<=1, tc<=1.
  - q==TERM, mode 10: q<=rld, tc<=1.
- ci=0 or done=1 (no clr/ld): q holds, tc<=0. tc is therefore never high for two consecutive cycles unless there are two consecutive terminal events.
- co = ci & (q==TERM) & ~done.
  - Purely combinational; no register in the path, so cascaded stages see the carry in the same cycle.
  - With done=1, co=0, so an expired one-shot never ripples into higher stages.
- Mode changes apply on the edge they are sampled. done stays set across a mode change until clr or ld.
- Reload with rld==TERM in mode 10: q stays at TERM and tc pulses on every ci=1 cycle.
- Reset asserted mid-count or mid-tc-pulse: all state cleared immediately, with no partial update.
- Width rule: the increment wraps modulo 2^WIDTH. There is no internal carry beyond WIDTH; only co leaves the block.

Optional Feature:
Macro: J_UPCNTN_DOWN_EN
- Defined:
  - Adds input port dn (1 bit). dn=1 makes the count step decrement (q-1) and TERM=0.
  - Mode 00 wraps to all ones. Mode 01 holds at 0 with done. Mode 10 reloads rld.
  - co becomes borrow-out: ci & (q==0) & ~done. dn is sampled per edge; changing it mid-count is legal.
- Not defined: the dn port is absent and the block is up-count only, exactly as described above.

Test Plan:
1. Reset then count: WIDTH=4, mode 00, ci=1 for 17 cycles -> q runs 0..15, 0. tc is high for exactly one cycle after q=15. co is high only while q==15.
2. One-shot: ld d=4'hD, mode 01, ci=1 -> q goes D,E,F and stops at F; done=1, tc single pulse, co=0 afterwards. A following ld of 4'h0 clears done.
3. Auto-reload: ld d=4'hC, mode 10, ci=1 for 12 cycles -> q sequence C,D,E,F,C,D,E,F,C,... with tc after each F.
4. Priority: clr=1 and ld=1 with d=4'h7 in the same cycle -> q=0 and the reload register stays at its old value. Next cycle ld alone with d=4'h7 -> q=7. ld with ci=1 at q==F -> q=d, no tc.
5. Cascade: two WIDTH=4 instances with co0->ci1, ci0=1 for 256 cycles -> the combined count wraps 0xFF->0x00 and the upper tc pulses once.
6. Async reset mid-count (q=0x9, tc high) with resl low between edges -> q=0, tc=0, done=0 before the next edge. With J_UPCNTN_DOWN_EN and dn=1 from q=1, mode 00 -> q goes 0 then F, borrow co high at q=0.
